// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
// vec_pkg : shared lane geometry, fp16 constants and writeback FSM encoding
// Revision: 1.0
// ============================================================================
package vec_pkg;

   localparam logic [14:0] FP16_MAX_MAG   = 15'h7BFF;
   localparam int          LANES          = 16;
   localparam int          LANES_PER_BEAT = 4;
   localparam int          LANE_W         = 16;
   localparam int          BEAT_W         = LANES_PER_BEAT * LANE_W;
   localparam int          VEC_W          = LANES * LANE_W;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BEAT0 = 3'd1,
      ST_BEAT1 = 3'd2,
      ST_BEAT2 = 3'd3,
      ST_BEAT3 = 3'd4,
      ST_FIN   = 3'd5
   } wb_state_e;

   function automatic logic is_beat(input wb_state_e s);
      return (s == ST_BEAT0) || (s == ST_BEAT1) || (s == ST_BEAT2) || (s == ST_BEAT3);
   endfunction

   // Beat number for a BEATk state; meaningless (but harmless) elsewhere.
   function automatic logic [1:0] beat_idx(input wb_state_e s);
      logic [2:0] d;
      d = 3'(s) - 3'(ST_BEAT0);
      return d[1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp16_sat4.sv
`default_nettype none
// ============================================================================
// fp16_sat4 : 4-lane fp16 saturator, overflowed lanes become signed max-finite
// Revision: 1.0
// ============================================================================
module fp16_sat4
   import vec_pkg::*;
#(
   parameter int SATURATE = 1
) (
   input  logic [BEAT_W-1:0]         data_i,
   input  logic [LANES_PER_BEAT-1:0] ovfl_i,
   output logic [BEAT_W-1:0]         data_o
);

   for (genvar i = 0; i < LANES_PER_BEAT; i++) begin : g_lane
      logic [LANE_W-1:0] w_lane;
      assign w_lane = data_i[i*LANE_W +: LANE_W];
      assign data_o[i*LANE_W +: LANE_W] =
         ((SATURATE != 0) && ovfl_i[i]) ? {w_lane[LANE_W-1], FP16_MAX_MAG} : w_lane;
   end

endmodule
`default_nettype wire

// File: rtl/vec_wb_ser4.sv
`default_nettype none
// ============================================================================
// vec_wb_ser4 : 4-beat vector register-file writeback with one pending slot
// Revision: 1.0
// ============================================================================
module vec_wb_ser4
   import vec_pkg::*;
#(
   parameter int REG_AW   = 3,
   parameter int SATURATE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              done,
   input  logic [255:0]      product,
   input  logic [15:0]       ovfl,
   input  logic [REG_AW-1:0] dest,
   input  logic              clr_sticky,
   output logic              wr_en,
   output logic [REG_AW+1:0] wr_addr,
   output logic [63:0]       wr_data,
   output logic              busy,
   output logic              wb_done,
   output logic              ovf_sticky,
   output logic              lost
);

   wb_state_e            state_q, state_d;
   logic [VEC_W-1:0]     act_data_q, act_data_d;
   logic [LANES-1:0]     act_ovfl_q, act_ovfl_d;
   logic [REG_AW-1:0]    act_dest_q, act_dest_d;
   logic                 pend_valid_q, pend_valid_d;
   logic [VEC_W-1:0]     pend_data_q, pend_data_d;
   logic [LANES-1:0]     pend_ovfl_q, pend_ovfl_d;
   logic [REG_AW-1:0]    pend_dest_q, pend_dest_d;
   logic                 sticky_d, lost_d;

   logic                 w_buffer_done;
   logic                 w_wr_en;
   logic [1:0]           w_beat;
   logic [BEAT_W-1:0]    w_beat_data;
   logic [3:0]           w_beat_ovfl;
   logic [BEAT_W-1:0]    w_sat_data;

   // A done arriving mid-writeback goes to the pending slot; in FIN with an
   // empty slot it is started directly, which is externally indistinguishable.
   assign w_buffer_done = (state_q != ST_IDLE) && !((state_q == ST_FIN) && !pend_valid_q);

   always_comb begin
      state_d      = state_q;
      act_data_d   = act_data_q;
      act_ovfl_d   = act_ovfl_q;
      act_dest_d   = act_dest_q;
      pend_valid_d = pend_valid_q;
      pend_data_d  = pend_data_q;
      pend_ovfl_d  = pend_ovfl_q;
      pend_dest_d  = pend_dest_q;
      lost_d       = lost;

      case (state_q)
         ST_IDLE: begin
            if (done) begin
               act_data_d = product;
               act_ovfl_d = ovfl;
               act_dest_d = dest;
               state_d    = ST_BEAT0;
            end
         end
         ST_BEAT0: state_d = ST_BEAT1;
         ST_BEAT1: state_d = ST_BEAT2;
         ST_BEAT2: state_d = ST_BEAT3;
         ST_BEAT3: state_d = ST_FIN;
         ST_FIN: begin
            if (pend_valid_q) begin
               act_data_d   = pend_data_q;
               act_ovfl_d   = pend_ovfl_q;
               act_dest_d   = pend_dest_q;
               pend_valid_d = 1'b0;
               state_d      = ST_BEAT0;
            end else if (done) begin
               act_data_d = product;
               act_ovfl_d = ovfl;
               act_dest_d = dest;
               state_d    = ST_BEAT0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (done && w_buffer_done) begin
         if (pend_valid_q) begin
            lost_d = 1'b1;
         end else begin
            pend_valid_d = 1'b1;
            pend_data_d  = product;
            pend_ovfl_d  = ovfl;
            pend_dest_d  = dest;
         end
      end

      sticky_d = ovf_sticky;
      if ((state_q == ST_BEAT0) && (|act_ovfl_q)) begin
         sticky_d = 1'b1;
      end else if (clr_sticky) begin
         sticky_d = 1'b0;
      end
   end

   // Outputs are registered, so the beat is selected from next-state values.
   assign w_wr_en     = is_beat(state_d);
   assign w_beat      = beat_idx(state_d);
   assign w_beat_data = act_data_d[{w_beat, 6'd0} +: BEAT_W];
   assign w_beat_ovfl = act_ovfl_d[{w_beat, 2'd0} +: LANES_PER_BEAT];

   fp16_sat4 #(
      .SATURATE (SATURATE)
   ) u_sat (
      .data_i (w_beat_data),
      .ovfl_i (w_beat_ovfl),
      .data_o (w_sat_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         act_data_q   <= '0;
         act_ovfl_q   <= '0;
         act_dest_q   <= '0;
         pend_valid_q <= 1'b0;
         pend_data_q  <= '0;
         pend_ovfl_q  <= '0;
         pend_dest_q  <= '0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         busy         <= 1'b0;
         wb_done      <= 1'b0;
         ovf_sticky   <= 1'b0;
         lost         <= 1'b0;
      end else begin
         state_q      <= state_d;
         act_data_q   <= act_data_d;
         act_ovfl_q   <= act_ovfl_d;
         act_dest_q   <= act_dest_d;
         pend_valid_q <= pend_valid_d;
         pend_data_q  <= pend_data_d;
         pend_ovfl_q  <= pend_ovfl_d;
         pend_dest_q  <= pend_dest_d;
         wr_en        <= w_wr_en;
         wr_addr      <= w_wr_en ? {act_dest_d, w_beat} : '0;
         wr_data      <= w_wr_en ? w_sat_data : '0;
         busy         <= (state_d != ST_IDLE) || pend_valid_d;
         wb_done      <= (state_d == ST_FIN);
         ovf_sticky   <= sticky_d;
         lost         <= lost_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vec_wb_ser4.sv
`default_nettype none
// ============================================================================
// tb_vec_wb_ser4 : scoreboard bench for vec_wb_ser4 (saturating and pass-through)
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_vec_wb_ser4;

   localparam int REG_AW = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              done = 1'b0;
   logic              clr_sticky = 1'b0;
   logic [255:0]      product = '0;
   logic [15:0]       ovfl = '0;
   logic [REG_AW-1:0] dest = '0;

   logic              wr_en, busy, wb_done, ovf_sticky, lost;
   logic [REG_AW+1:0] wr_addr;
   logic [63:0]       wr_data;
   logic              n_wr_en, n_busy, n_wb_done, n_ovf_sticky, n_lost;
   logic [REG_AW+1:0] n_wr_addr;
   logic [63:0]       n_wr_data;

   typedef struct packed {
      logic [REG_AW+1:0] addr;
      logic [63:0]       data;
   } beat_t;

   beat_t exp_q[$];
   beat_t exp_ns_q[$];
   int    errors = 0;
   int    checks = 0;

   vec_wb_ser4 #(.REG_AW(REG_AW), .SATURATE(1)) dut (
      .clk(clk), .rst_n(rst_n), .done(done), .product(product), .ovfl(ovfl),
      .dest(dest), .clr_sticky(clr_sticky), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .wb_done(wb_done), .ovf_sticky(ovf_sticky),
      .lost(lost)
   );

   vec_wb_ser4 #(.REG_AW(REG_AW), .SATURATE(0)) dut_ns (
      .clk(clk), .rst_n(rst_n), .done(done), .product(product), .ovfl(ovfl),
      .dest(dest), .clr_sticky(clr_sticky), .wr_en(n_wr_en), .wr_addr(n_wr_addr),
      .wr_data(n_wr_data), .busy(n_busy), .wb_done(n_wb_done), .ovf_sticky(n_ovf_sticky),
      .lost(n_lost)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] model_beat(input logic [255:0] p, input logic [15:0] o,
                                              input int k, input bit sat);
      logic [63:0] r;
      r = '0;
      for (int l = 0; l < 4; l++) begin
         logic [15:0] v;
         v = p[(4*k+l)*16 +: 16];
         if (sat && o[4*k+l]) v = {v[15], 15'h7BFF};
         r[l*16 +: 16] = v;
      end
      return r;
   endfunction

   function automatic logic [255:0] make_vec(input logic [7:0] seed);
      logic [255:0] r;
      for (int i = 0; i < 16; i++) r[i*16 +: 16] = {seed, 8'(i)};
      return r;
   endfunction

   task automatic push_vec(input logic [255:0] p, input logic [15:0] o, input logic [REG_AW-1:0] d);
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back('{addr: {d, 2'(k)}, data: model_beat(p, o, k, 1'b1)});
         exp_ns_q.push_back('{addr: {d, 2'(k)}, data: model_beat(p, o, k, 1'b0)});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_done(input logic [255:0] p, input logic [15:0] o, input logic [REG_AW-1:0] d);
      product = p;
      ovfl    = o;
      dest    = d;
      done    = 1'b1;
      tick();
      done    = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!busy && !wr_en && !wb_done) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check({name, "_idle_timeout"}, 64'(ok), 64'd1);
   endtask

   // Scoreboard monitor for the saturating instance
   initial begin
      beat_t e;
      logic  prev_beat3;
      prev_beat3 = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_beat3 = 1'b0;
         end else begin
            check("wb_done_timing", 64'(wb_done), 64'(prev_beat3));
            if (wr_en) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: addr %h data %h, none expected at %0t",
                           wr_addr, wr_data, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("wr_addr", 64'(wr_addr), 64'(e.addr));
                  check("wr_data", wr_data, e.data);
               end
            end else begin
               check("idle_addr", 64'(wr_addr), 64'd0);
               check("idle_data", wr_data, 64'd0);
            end
            prev_beat3 = wr_en && (wr_addr[1:0] == 2'd3);
         end
      end
   end

   // Scoreboard monitor for the pass-through instance
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (rst_n && n_wr_en) begin
            if (exp_ns_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ns_unexpected_write: addr %h data %h at %0t", n_wr_addr, n_wr_data, $time);
            end else begin
               e = exp_ns_q.pop_front();
               check("ns_wr_addr", 64'(n_wr_addr), 64'(e.addr));
               check("ns_wr_data", n_wr_data, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [255:0] p, va, vb, vc;

      // Reset values
      tick(); tick();
      check("rst_wr_en", 64'(wr_en), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_sticky", 64'(ovf_sticky), 64'd0);
      check("rst_lost", 64'(lost), 64'd0);
      rst_n = 1'b1;
      tick();

      // 1: plain vector to register 5
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back('{addr: 5'h14 + 5'(k), data: 64'h3C00_3C00_3C00_3C00});
         exp_ns_q.push_back('{addr: 5'h14 + 5'(k), data: 64'h3C00_3C00_3C00_3C00});
      end
      pulse_done({16{16'h3C00}}, 16'h0000, 3'd5);
      check("t1_busy", 64'(busy), 64'd1);
      tick(); tick(); tick(); tick();
      check("t1_wb_done", 64'(wb_done), 64'd1);
      check("t1_sticky", 64'(ovf_sticky), 64'd0);
      wait_idle("t1");
      check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

      // 2: saturation of lanes 2 and 9, pass-through in the second instance
      for (int i = 0; i < 16; i++) p[i*16 +: 16] = 16'h0100 + 16'(i);
      p[2*16 +: 16] = 16'hC000;
      p[9*16 +: 16] = 16'h7000;
      exp_q.push_back('{addr: 5'h0C, data: 64'h0103_FBFF_0101_0100});
      exp_q.push_back('{addr: 5'h0D, data: 64'h0107_0106_0105_0104});
      exp_q.push_back('{addr: 5'h0E, data: 64'h010B_010A_7BFF_0108});
      exp_q.push_back('{addr: 5'h0F, data: 64'h010F_010E_010D_010C});
      exp_ns_q.push_back('{addr: 5'h0C, data: 64'h0103_C000_0101_0100});
      exp_ns_q.push_back('{addr: 5'h0D, data: 64'h0107_0106_0105_0104});
      exp_ns_q.push_back('{addr: 5'h0E, data: 64'h010B_010A_7000_0108});
      exp_ns_q.push_back('{addr: 5'h0F, data: 64'h010F_010E_010D_010C});
      pulse_done(p, 16'h0204, 3'd3);
      tick(); tick(); tick(); tick();
      check("t2_sticky", 64'(ovf_sticky), 64'd1);
      wait_idle("t2");
      check("t2_ns_queue_empty", 64'(exp_ns_q.size()), 64'd0);

      // 3: second done two cycles after the first is buffered
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      check("t3_sticky_cleared", 64'(ovf_sticky), 64'd0);
      va = make_vec(8'hA1);
      vb = make_vec(8'hB2);
      push_vec(va, 16'h0, 3'd1);
      push_vec(vb, 16'h0, 3'd2);
      pulse_done(va, 16'h0, 3'd1);
      tick();
      pulse_done(vb, 16'h0, 3'd2);
      check("t3_busy_pending", 64'(busy), 64'd1);
      tick(); tick();
      check("t3_fin_wb_done", 64'(wb_done), 64'd1);
      check("t3_fin_busy", 64'(busy), 64'd1);
      tick();
      check("t3_b2_beat0_en", 64'(wr_en), 64'd1);
      check("t3_b2_beat0_addr", 64'(wr_addr), 64'h08);
      wait_idle("t3");
      check("t3_lost", 64'(lost), 64'd0);
      check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

      // 4: three back-to-back dones, the third is dropped
      va = make_vec(8'h41);
      vb = make_vec(8'h62);
      vc = make_vec(8'h73);
      push_vec(va, 16'h0, 3'd4);
      push_vec(vb, 16'h0, 3'd6);
      pulse_done(va, 16'h0, 3'd4);
      pulse_done(vb, 16'h0, 3'd6);
      pulse_done(vc, 16'h0, 3'd7);
      check("t4_lost_set", 64'(lost), 64'd1);
      wait_idle("t4");
      check("t4_lost_held", 64'(lost), 64'd1);
      check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

      // 5: clear coincident with BEAT0 of an overflowing vector loses to set
      check("t5_sticky_pre", 64'(ovf_sticky), 64'd0);
      va = make_vec(8'hC3);
      push_vec(va, 16'h8000, 3'd0);
      pulse_done(va, 16'h8000, 3'd0);
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      check("t5_set_wins", 64'(ovf_sticky), 64'd1);
      wait_idle("t5");
      check("t5_sticky_held", 64'(ovf_sticky), 64'd1);
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      check("t5_sticky_clr", 64'(ovf_sticky), 64'd0);

      // 6: reset during BEAT2 with a pending result
      va = make_vec(8'h5A);
      vb = make_vec(8'h6B);
      push_vec(va, 16'h0, 3'd2);
      pulse_done(va, 16'h0, 3'd2);
      pulse_done(vb, 16'h0, 3'd3);
      tick();
      rst_n = 1'b0;
      exp_q.delete();
      exp_ns_q.delete();
      #1;
      check("t6_rst_wr_en", 64'(wr_en), 64'd0);
      check("t6_rst_wr_data", wr_data, 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_lost", 64'(lost), 64'd0);
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("t6_post_busy", 64'(busy), 64'd0);
      vc = make_vec(8'h7C);
      push_vec(vc, 16'h0, 3'd7);
      pulse_done(vc, 16'h0, 3'd7);
      wait_idle("t6");
      check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vec_wb_ser4.md
Name: vec_wb_ser4

Overview:
Writeback stage directly downstream of the 4-lane serial fp16 vector-scalar multiplier. It captures the multiplier's 256-bit product and 16 lane-overflow flags on the done pulse. It then writes the vector into the vector register file over four 64-bit beats. Overflowed lanes are optionally saturated, sticky overflow status is maintained, and one pending result is buffered while a writeback is in progress.

Parameters:
REG_AW, 3, vector register index width (8 vector registers)
SATURATE, 1, 1 = replace overflowed lanes with signed fp16 max-finite; 0 = pass through

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
done  in  1  result-valid pulse from multiplier (one cycle)
product  in  256  16 fp16 lanes, lane i = bits [16i+15:16i]
ovfl  in  16  per-lane overflow flags, bit i = lane i
dest  in  REG_AW  destination vector register, sampled with done
clr_sticky  in  1  clears ovf_sticky
wr_en  out  1  register-file write strobe
wr_addr  out  REG_AW+2  {dest, beat[1:0]}
wr_data  out  64  four lanes for the current beat
busy  out  1  writeback in progress or pending slot full
wb_done  out  1  one-cycle pulse after the last beat of a vector
ovf_sticky  out  1  OR of all overflow flags written since the last clear
lost  out  1  sticky; set when a result is dropped

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM in IDLE, active and pending slots empty. Reset during a writeback abandons the remaining beats and discards the pending slot.
- FSM states and transitions:
  - IDLE -> BEAT0 on a captured result.
  - BEAT0 -> BEAT1 -> BEAT2 -> BEAT3 -> FIN, unconditionally.
  - FIN -> BEAT0 if the pending slot is valid (pending moves to active); otherwise FIN -> IDLE.
- Capture: done sampled high in cycle N while in IDLE loads product, ovfl and dest into the active slot.
  - wr_en=1 during N+1..N+4, with beat k (wr_addr low bits = k) carrying lanes 4k..4k+3, i.e. product bits [64k+63:64k].
  - wb_done=1 in N+5 (FIN).
- Pending slot:
  - done while not IDLE and pending slot empty -> captured into the pending slot.
  - done while the pending slot is full -> result dropped, lost set (cleared only by reset).
  - done in FIN with the pending slot empty -> captured into pending; the next writeback starts at the following cycle.
- busy = (state != IDLE) | pending_valid.
- Saturation (SATURATE=1), per lane with ovfl[i]=1: output = {product[16i+15], 15'h7BFF}, i.e. 0x7BFF or 0xFBFF. Lanes with ovfl[i]=0 pass unchanged. SATURATE=0: all lanes pass unchanged.
- ovf_sticky:
  - Sets when any ovfl bit of the active slot is 1; evaluated in BEAT0.
  - clr_sticky clears it in the next cycle.
  - Simultaneous set and clear: set wins.
- wr_data and wr_addr hold 0 when wr_en=0.
- done is a single-cycle pulse from the multiplier's clock domain. That domain must already be retimed to clk by the integrating level; this block performs no synchronisation.

Decomposition:
- Shared package vec_pkg holds:
  - FP16_MAX_MAG = 15'h7BFF
  - LANES = 16, LANES_PER_BEAT = 4, LANE_W = 16
  - the FSM state encoding (IDLE, BEAT0-BEAT3, FIN)
- Sub-module fp16_sat4: combinational 4-lane saturator (64-bit data plus 4 overflow flags in, 64-bit data out), instanced once on the beat mux output.

Test Plan:
1. Reset, then done with product = 16 lanes of 0x3C00, ovfl=0, dest=5 -> beats at wr_addr 0x14..0x17, each wr_data=0x3C003C003C003C00; wb_done one cycle after beat 3; ovf_sticky=0.
2. Lane 2 = 0xC000 with ovfl=16'h0004, lane 9 = 0x7000 with ovfl bit 9, SATURATE=1 -> beat 0 lane 2 = 0xFBFF, beat 2 lane 1 = 0x7BFF; ovf_sticky=1. With SATURATE=0 the lanes pass through unchanged.
3. done again 2 cycles after the first capture -> buffered, busy held; second vector's beat 0 immediately follows FIN of the first; lost stays 0.
4. Three done pulses within the first writeback -> third dropped, lost=1, only two vectors written.
5. clr_sticky asserted in the same cycle as BEAT0 of an overflowing vector -> ovf_sticky stays 1; clr_sticky alone later -> ovf_sticky=0 next cycle.
6. rst_n low during BEAT2 with a pending result -> outputs 0 immediately; after release no further wr_en until a new done arrives.
